// File: rtl/au_arbiter.sv
// au_arbiter: round-robin share of one arithmetic unit among NREQ requesters; operands latched at grant.
// Latency: req seen in IDLE at cycle 0 -> au_start cycle 1 -> rsp_valid the cycle after au_done (>= 4 cycles/op).
// Backpressure: requesters hold req until their rsp_valid; losers just wait. Optional watchdog: AU_ARB_TIMEOUT_EN.
module au_arbiter #(
  parameter int W       = 24,
  parameter int NREQ    = 2,
  parameter int TMO_CYC = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [2*NREQ-1:0]   req_op,
  input  logic [W*NREQ-1:0]   req_r,
  input  logic [W*NREQ-1:0]   req_s,
  output logic [NREQ-1:0]     grant,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [W-1:0]        rsp_result,
  output logic                rsp_err,
  output logic                au_start,
  output logic [1:0]          au_op,
  output logic [W-1:0]        au_r,
  output logic [W-1:0]        au_s,
  input  logic [W-1:0]        au_result,
  input  logic                au_done
);

  localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [RW-1:0]   rr_q, rr_d;
  logic [RW-1:0]   owner_q, owner_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [1:0]      op_q, op_d;
  logic [W-1:0]    r_q, r_d;
  logic [W-1:0]    s_q, s_d;
  logic [W-1:0]    result_q, result_d;

  logic            pick_vld;
  logic [RW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_oh;
  logic [1:0]      pick_op;
  logic [W-1:0]    pick_r;
  logic [W-1:0]    pick_s;

`ifdef AU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TMO_CYC + 1);
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
`else
  // The watchdog limit has no role when the watchdog is not built.
  logic            unused_tmo_cfg;
  assign unused_tmo_cfg = (TMO_CYC > 0);
`endif

  // Round-robin pick: first pass covers indices >= rr pointer, second pass wraps to the low indices.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    pick_oh  = '0;
    pick_op  = '0;
    pick_r   = '0;
    pick_s   = '0;
    for (int k = 0; k < 2*NREQ; k++) begin
      if (!pick_vld && req[k % NREQ] && ((k >= NREQ) || (RW'(k) >= rr_q))) begin
        pick_vld = 1'b1;
        pick_idx = RW'(k % NREQ);
        pick_oh[k % NREQ] = 1'b1;
        pick_op  = req_op[2*(k % NREQ) +: 2];
        pick_r   = req_r[W*(k % NREQ) +: W];
        pick_s   = req_s[W*(k % NREQ) +: W];
      end
    end
  end

  // Next-state logic: IDLE -> ISSUE -> WAIT -> RESP -> IDLE, one op in flight.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    op_d     = op_q;
    r_d      = r_q;
    s_d      = s_q;
    result_d = result_q;
`ifdef AU_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // A late au_done landing here is deliberately ignored.
        if (pick_vld) begin
          owner_d = pick_idx;
          grant_d = pick_oh;
          op_d    = pick_op;
          r_d     = pick_r;
          s_d     = pick_s;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
`ifdef AU_ARB_TIMEOUT_EN
        cnt_d   = '0;
        err_d   = 1'b0;
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (au_done) begin
          result_d = au_result;
          state_d  = ST_RESP;
        end
`ifdef AU_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TMO_CYC)) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_RESP: begin
        rr_d    = (owner_q == RW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched-operand registers; reset aborts any op in flight without a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_q     <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
      op_q     <= '0;
      r_q      <= '0;
      s_q      <= '0;
      result_q <= '0;
`ifdef AU_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      op_q     <= op_d;
      r_q      <= r_d;
      s_q      <= s_d;
      result_q <= result_d;
`ifdef AU_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign grant      = grant_q;
  assign rsp_valid  = (state_q == ST_RESP) ? grant_q : '0;
  assign rsp_result = result_q;
  assign au_start   = (state_q == ST_ISSUE);
  assign au_op      = op_q;
  assign au_r       = r_q;
  assign au_s       = s_q;
`ifdef AU_ARB_TIMEOUT_EN
  assign rsp_err    = (state_q == ST_RESP) & err_q;
`else
  assign rsp_err    = 1'b0;
`endif

endmodule
